// File: rtl/risc_seq_divider.sv
// Iterative restoring divider for the execute stage.
// One quotient bit per clock; signs are fixed up in a single cycle after the loop.
module risc_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic             dd_neg;
    logic             dv_neg;
    logic [WIDTH-1:0] dd_abs;
    logic [WIDTH-1:0] dv_abs;
    logic [WIDTH:0]   rem_shift;
    logic             fits;

    always_comb begin
        dd_neg    = signed_op & dividend[WIDTH-1];
        dv_neg    = signed_op & divisor[WIDTH-1];
        dd_abs    = dd_neg ? -dividend : dividend;
        dv_abs    = dv_neg ? -divisor : divisor;
        // Remainder is always below the divisor, so WIDTH+1 bits cover the shift.
        rem_shift = {rem_q, dq_q[WIDTH-1]};
        fits      = rem_shift >= {1'b0, dvs_q};

        state_d  = state_q;
        cnt_d    = cnt_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        quo_d    = quo_q;
        remo_d   = remo_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                state_d = S_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d = S_FIN;
                        quo_d   = '1;
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        dq_d     = dd_abs;
                        dvs_d    = dv_abs;
                        rem_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        sign_q_d = dd_neg ^ dv_neg;
                        sign_r_d = dd_neg;
                    end
                end
            end
            S_RUN: begin
                dq_d  = {dq_q[WIDTH-2:0], fits};
                rem_d = fits ? (rem_shift[WIDTH-1:0] - dvs_q)
                             : rem_shift[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                quo_d   = sign_q_q ? -dq_q : dq_q;
                remo_d  = sign_r_q ? -rem_q : rem_q;
                dbz_d   = 1'b0;
                state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_FIN);
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            quo_q    <= '0;
            remo_q   <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            quo_q    <= quo_d;
            remo_q   <= remo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_risc_seq_divider.sv
// Directed and random checks of risc_seq_divider against an arithmetic model.
// Expected results come from SystemVerilog integer divide and modulo.
module tb_risc_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    risc_seq_divider #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic sop, input logic [15:0] a,
                                  input logic [15:0] b,
                                  output logic [15:0] q,
                                  output logic [15:0] r,
                                  output logic z);
        int sa;
        int sb;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
        end else if (sop) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = 16'(sa / sb);
            r  = 16'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic issue(input logic sop, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        start     = 1'b1;
        signed_op = sop;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic sop,
                                input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        model(sop, a, b, eq, er, ez);
        chk({tag, "_done"}, 32'(done), 32'(1));
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        chk({tag, "_busy_end"}, 32'(busy), 32'(0));
    endtask

    task automatic do_op(input string tag, input logic sop,
                         input logic [15:0] a, input logic [15:0] b,
                         input bit follow);
        int          edges;
        logic [15:0] q_hold;
        issue(sop, a, b);
        if (b != 16'd0) chk({tag, "_busy"}, 32'(busy), 32'(1));
        else chk({tag, "_busy0"}, 32'(busy), 32'(0));
        wait_done(edges);
        chk({tag, "_lat"}, 32'(edges), (b == 16'd0) ? 32'(1) : 32'(18));
        check_result(tag, sop, a, b);
        if (follow) begin
            q_hold = quotient;
            @(posedge clk);
            #1;
            chk({tag, "_done_pulse"}, 32'(done), 32'(0));
            chk({tag, "_hold"}, 32'(quotient), 32'(q_hold));
        end
    endtask

    initial begin
        int          edges;
        int          n_done;
        logic [15:0] a;
        logic [15:0] b;
        logic        sop;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_q", 32'(quotient), 32'(0));
        chk("rst_r", 32'(remainder), 32'(0));
        chk("rst_dbz", 32'(div_by_zero), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);

        do_op("t1", 1'b0, 16'd100, 16'd7, 1'b1);
        do_op("t2a", 1'b1, 16'hFF9C, 16'd7, 1'b1);
        do_op("t2b", 1'b1, 16'd100, 16'hFFF9, 1'b1);
        do_op("t3", 1'b0, 16'd1234, 16'd0, 1'b1);
        do_op("t3s", 1'b1, 16'h8001, 16'd0, 1'b1);
        do_op("t4s", 1'b1, 16'h8000, 16'hFFFF, 1'b1);
        do_op("t4u", 1'b0, 16'h8000, 16'hFFFF, 1'b1);
        do_op("max", 1'b0, 16'hFFFF, 16'd1, 1'b1);
        do_op("small", 1'b0, 16'd3, 16'hFFFF, 1'b1);

        // Start during RUN is ignored; start in the done cycle is accepted.
        issue(1'b0, 16'd100, 16'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges);
        check_result("t5a", 1'b0, 16'd100, 16'd7);
        do_op("t5b", 1'b0, 16'd50, 16'd5, 1'b1);

        // Back-to-back divide-by-zero ops keep done high two cycles.
        do_op("bz1", 1'b0, 16'd9, 16'd0, 1'b0);
        do_op("bz2", 1'b0, 16'd77, 16'd0, 1'b1);

        // Reset in the middle of an operation.
        issue(1'b0, 16'd100, 16'd7);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_done", 32'(done), 32'(0));
        chk("t6_q", 32'(quotient), 32'(0));
        chk("t6_r", 32'(remainder), 32'(0));
        n_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("t6_no_done", 32'(n_done), 32'(0));
        do_op("t6_new", 1'b1, 16'hFC18, 16'd33, 1'b1);

        for (int i = 0; i < 150; i++) begin
            sop = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            case ($urandom_range(0, 9))
                0: b = 16'd0;
                1: b = 16'hFFFF;
                2: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) a = 16'h8000;
            do_op("rnd", sop, a, b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
